sobel_vga_out: RTL and testbench
================================

// Module: sobel_vga_out
// PURPOSE
//   Downstream stage of the Sobel top: captures the filtered pixel stream (PIXEL/PIXEL_EN) into an on-chip frame buffer.
//   Scans the buffer out as an 800x600@60 SVGA raster (40 MHz pixel clock = CLK), image window fixed at offset (X0,Y0).
//   Write side is driven by the filter; read side is free-running VGA timing. Both run on the same clock.
// PARAMETERS
//   IMG_W    538  image width in pixels (Sobel output columns)
//   IMG_H    538  image height in pixels (Sobel output rows)
//   X0       131  horizontal offset of image window inside 800 visible columns
//   Y0       31   vertical offset of image window inside 600 visible lines
// PORTS
//   CLK              in   1  pixel/system clock, 40 MHz
//   RST              in   1  asynchronous, active-high reset
//   FRAME_START_I    in   1  1-cycle pulse, issued with CORE_RUN; rewinds write address to 0
//   PIXEL_I          in   8  filtered grey pixel
//   PIXEL_EN_I       in   1  PIXEL_I valid this cycle; no backpressure
//   FRAME_WR_DONE_O  out  1  1-cycle pulse when pixel IMG_W*IMG_H-1 is written
//   VGA_PIXEL_O      out  8  grey output; 0 outside window or before first full frame
//   VGA_HSYNC_O      out  1  horizontal sync, active-high
//   VGA_VSYNC_O      out  1  vertical sync, active-high
//   VGA_DE_O         out  1  display enable (visible 800x600 area)
// BEHAVIOUR
//   Reset: all outputs 0; wr_addr=0, h_cnt=v_cnt=0, rd_addr=0, frame_valid=0. RAM contents are not cleared.
//   Write side
//   - On PIXEL_EN_I: RAM[wr_addr] <= PIXEL_I, then wr_addr++.
//   - At wr_addr==IMG_W*IMG_H-1: wrap to 0, pulse FRAME_WR_DONE_O next cycle, set frame_valid (sticky until RST).
//   - FRAME_START_I: wr_addr <= 0. If FRAME_START_I and PIXEL_EN_I coincide, pixel goes to address 0 and wr_addr becomes 1.
//   - Extra pixels beyond a frame wrap and overwrite from address 0. No error flag.
//   Timing (stage 0 counters)
//   - h_cnt 0..1055, wraps to 0. On wrap, v_cnt increments 0..627, then wraps to 0.
//   - H: visible 0..799, front porch 800..839, sync 840..967, back porch 968..1055.
//   - V: visible 0..599, front porch 600, sync 601..604, back porch 605..627.
//   - win = (h_cnt in [X0,X0+IMG_W-1]) && (v_cnt in [Y0,Y0+IMG_H-1]).
//   Read address
//   - Incremental, no multiplier: rd_addr++ on every win cycle.
//   - rd_addr cleared at h_cnt==0 && v_cnt==0. Never exceeds IMG_W*IMG_H-1 within a frame.
//   Pipeline
//   - Stage 1 registers rd_addr into the RAM plus win/de/hs/vs.
//   - RAM is synchronous, 1-cycle read latency.
//   - Stage 2 registers all outputs. Fixed latency 2 CLK from counter value to HSYNC/VSYNC/DE/PIXEL, all aligned.
//   - VGA_PIXEL_O = (win_d2 && frame_valid) ? ram_q : 8'h00.
//   Simultaneous read/write of same address: read returns old data (read-first). Tearing is accepted.
// CONFIGURATION
//   VGA_BORDER_EN defined: pixels on the 1-pixel ring just outside the window output 8'hFF whenever DE is high, regardless of frame_valid.
//   - Ring: h in {X0-1, X0+IMG_W}, or v in {Y0-1, Y0+IMG_H}, with the other coordinate in range extended by 1.
//   VGA_BORDER_EN undefined: the ring outputs 0, same as the rest of the background.
// STRUCTURE
//   vga_timing_pkg: H_VIS/H_FP/H_SYNC/H_BP/H_TOTAL and V_* constants, plus the address-width function clog2(IMG_W*IMG_H).
//   Sub-module frame_ram: simple dual-port RAM (1 write port, 1 sync read port), depth IMG_W*IMG_H, width 8, read-first.
// TESTING
//   1 Reset mid-line (h_cnt=500): all outputs 0 within reset; after release, HSYNC rises at cycle 840+2, VSYNC at line 601.
//   2 Free-run one frame: HSYNC high 128 CLK per line; VSYNC high 4*1056 CLK; DE high 800 of 1056 per line; 628 lines.
//   3 No pixels written: VGA_PIXEL_O stays 0 for a full frame.
//   4 Write IMG_W*IMG_H ramp pixels (data = addr[7:0]):
//     - FRAME_WR_DONE_O pulses once.
//     - Next frame: at h=X0,v=Y0, output 8'h00 two cycles later; at h=X0+1, 8'h01; at h=X0,v=Y0+1, (538)%256 = 8'h1A.
//   5 FRAME_START_I coinciding with PIXEL_EN_I (value 8'hAB) mid-frame: RAM[0]=8'hAB; next write lands at address 1.
//   6 VGA_BORDER_EN build: at (X0-1,Y0), output 8'hFF; at (X0-2,Y0), output 0. Non-border build: both 0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// SVGA 800x600@60 raster constants and the address-width helper shared by the
// Sobel VGA output stage.
package vga_timing_pkg;

    localparam int H_VIS   = 800;
    localparam int H_FP    = 40;
    localparam int H_SYNC  = 128;
    localparam int H_BP    = 88;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 600;
    localparam int V_FP    = 1;
    localparam int V_SYNC  = 4;
    localparam int V_BP    = 23;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Never returns 0 so a one-entry space still gets a 1-bit address.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port,
// read-first on address collision.
module frame_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_data_o <= mem[rd_addr_i];
    end

endmodule

// File: rtl/sobel_vga_out.sv
// Captures the filtered pixel stream into a frame buffer and scans it out as a
// fixed-window SVGA raster. Optional VGA_BORDER_EN draws a white 1-pixel frame.
module sobel_vga_out
    import vga_timing_pkg::*;
#(
    parameter int IMG_W = 538,
    parameter int IMG_H = 538,
    parameter int X0    = 131,
    parameter int Y0    = 31,
    parameter int HVIS  = H_VIS,
    parameter int HFP   = H_FP,
    parameter int HSW   = H_SYNC,
    parameter int HBP   = H_BP,
    parameter int VVIS  = V_VIS,
    parameter int VFP   = V_FP,
    parameter int VSW   = V_SYNC,
    parameter int VBP   = V_BP
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       FRAME_START_I,
    input  logic [7:0] PIXEL_I,
    input  logic       PIXEL_EN_I,
    output logic       FRAME_WR_DONE_O,
    output logic [7:0] VGA_PIXEL_O,
    output logic       VGA_HSYNC_O,
    output logic       VGA_VSYNC_O,
    output logic       VGA_DE_O
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW   = clog2(NPIX);
    localparam int HTOT = HVIS + HFP + HSW + HBP;
    localparam int VTOT = VVIS + VFP + VSW + VBP;
    localparam int HW   = clog2(HTOT);
    localparam int VW   = clog2(VTOT);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [HW-1:0] H_LAST    = HW'(HTOT - 1);
    localparam logic [VW-1:0] V_LAST    = VW'(VTOT - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d, rd_sel;
    logic [AW-1:0] wr_addr_q, wr_addr_d, wr_sel;
    logic          frame_valid_q, frame_valid_d, wr_done_d;
    int            h_pos, v_pos;
    logic          win, de, hs, vs, ring;
    logic          win_d1, de_d1, hs_d1, vs_d1, ring_d1;
    logic [7:0]    ram_q, pixel_d;

    assign h_pos = int'(h_cnt_q);
    assign v_pos = int'(v_cnt_q);

    assign win = (h_pos >= X0) && (h_pos <= X0 + IMG_W - 1) &&
                 (v_pos >= Y0) && (v_pos <= Y0 + IMG_H - 1);
    assign de  = (h_pos < HVIS) && (v_pos < VVIS);
    assign hs  = (h_pos >= HVIS + HFP) && (h_pos < HVIS + HFP + HSW);
    assign vs  = (v_pos >= VVIS + VFP) && (v_pos < VVIS + VFP + VSW);

`ifdef VGA_BORDER_EN
    assign ring = ((h_pos == X0 - 1 || h_pos == X0 + IMG_W) &&
                   v_pos >= Y0 - 1 && v_pos <= Y0 + IMG_H) ||
                  ((v_pos == Y0 - 1 || v_pos == Y0 + IMG_H) &&
                   h_pos >= X0 - 1 && h_pos <= X0 + IMG_W);
`else
    assign ring = 1'b0;
`endif

    // Raster counters and incremental read address; the read address is forced
    // to 0 at the raster origin so a corrupted count cannot survive a frame.
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
        rd_sel    = (h_cnt_q == '0 && v_cnt_q == '0) ? '0 : rd_addr_q;
        rd_addr_d = rd_sel;
        if (win) begin
            rd_addr_d = (rd_sel == LAST_ADDR) ? '0 : rd_sel + 1'b1;
        end
    end

    // A frame start coinciding with a pixel writes that pixel to address 0.
    always_comb begin
        wr_sel    = FRAME_START_I ? '0 : wr_addr_q;
        wr_addr_d = wr_sel;
        wr_done_d = 1'b0;
        if (PIXEL_EN_I) begin
            wr_done_d = (wr_sel == LAST_ADDR);
            wr_addr_d = wr_done_d ? '0 : wr_sel + 1'b1;
        end
        frame_valid_d = frame_valid_q | wr_done_d;
    end

    always_comb begin
        pixel_d = 8'h00;
        if (win_d1 && frame_valid_q) pixel_d = ram_q;
        if (ring_d1 && de_d1)        pixel_d = 8'hFF;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            h_cnt_q         <= '0;
            v_cnt_q         <= '0;
            rd_addr_q       <= '0;
            wr_addr_q       <= '0;
            frame_valid_q   <= 1'b0;
            win_d1          <= 1'b0;
            de_d1           <= 1'b0;
            hs_d1           <= 1'b0;
            vs_d1           <= 1'b0;
            ring_d1         <= 1'b0;
            FRAME_WR_DONE_O <= 1'b0;
            VGA_PIXEL_O     <= 8'h00;
            VGA_HSYNC_O     <= 1'b0;
            VGA_VSYNC_O     <= 1'b0;
            VGA_DE_O        <= 1'b0;
        end else begin
            h_cnt_q         <= h_cnt_d;
            v_cnt_q         <= v_cnt_d;
            rd_addr_q       <= rd_addr_d;
            wr_addr_q       <= wr_addr_d;
            frame_valid_q   <= frame_valid_d;
            win_d1          <= win;
            de_d1           <= de;
            hs_d1           <= hs;
            vs_d1           <= vs;
            ring_d1         <= ring;
            FRAME_WR_DONE_O <= wr_done_d;
            VGA_PIXEL_O     <= pixel_d;
            VGA_HSYNC_O     <= hs_d1;
            VGA_VSYNC_O     <= vs_d1;
            VGA_DE_O        <= de_d1;
        end
    end

    frame_ram #(
        .DEPTH (NPIX),
        .AW    (AW)
    ) u_frame_ram (
        .clk_i     (CLK),
        .we_i      (PIXEL_EN_I),
        .wr_addr_i (wr_sel),
        .wr_data_i (PIXEL_I),
        .rd_addr_i (rd_sel),
        .rd_data_o (ram_q)
    );

endmodule

// File: tb/tb_sobel_vga_out.sv
// Bench for sobel_vga_out on a scaled-down raster so whole frames fit in a short run.
module tb_sobel_vga_out;

    localparam int IMG_W = 16;
    localparam int IMG_H = 12;
    localparam int X0    = 7;
    localparam int Y0    = 5;
    localparam int HVIS  = 40;
    localparam int HFP   = 4;
    localparam int HSW   = 8;
    localparam int HBP   = 8;
    localparam int VVIS  = 30;
    localparam int VFP   = 1;
    localparam int VSW   = 4;
    localparam int VBP   = 3;
    localparam int HT    = HVIS + HFP + HSW + HBP;
    localparam int VT    = VVIS + VFP + VSW + VBP;
    localparam int FT    = HT * VT;
    localparam int NPIX  = IMG_W * IMG_H;
`ifdef VGA_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       FRAME_START_I = 1'b0;
    logic [7:0] PIXEL_I = 8'h00;
    logic       PIXEL_EN_I = 1'b0;
    logic       FRAME_WR_DONE_O;
    logic [7:0] VGA_PIXEL_O;
    logic       VGA_HSYNC_O, VGA_VSYNC_O, VGA_DE_O;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] mem_model [NPIX];
    int         m_wr = 0;
    bit         m_valid = 1'b0;

    logic [7:0] obs_pix [VT][HT];
    logic       obs_de  [VT][HT];
    logic       obs_hs  [VT][HT];
    logic       obs_vs  [VT][HT];

    sobel_vga_out #(
        .IMG_W (IMG_W), .IMG_H (IMG_H), .X0 (X0), .Y0 (Y0),
        .HVIS (HVIS), .HFP (HFP), .HSW (HSW), .HBP (HBP),
        .VVIS (VVIS), .VFP (VFP), .VSW (VSW), .VBP (VBP)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .FRAME_START_I   (FRAME_START_I),
        .PIXEL_I         (PIXEL_I),
        .PIXEL_EN_I      (PIXEL_EN_I),
        .FRAME_WR_DONE_O (FRAME_WR_DONE_O),
        .VGA_PIXEL_O     (VGA_PIXEL_O),
        .VGA_HSYNC_O     (VGA_HSYNC_O),
        .VGA_VSYNC_O     (VGA_VSYNC_O),
        .VGA_DE_O        (VGA_DE_O)
    );

    always #5 CLK = ~CLK;

    // cyc = clock edges since reset release; output at cyc shows raster position cyc-2.
    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic bit m_de(input int h, input int v);
        return (h < HVIS) && (v < VVIS);
    endfunction

    function automatic bit m_hs(input int h);
        return (h >= HVIS + HFP) && (h < HVIS + HFP + HSW);
    endfunction

    function automatic bit m_vs(input int v);
        return (v >= VVIS + VFP) && (v < VVIS + VFP + VSW);
    endfunction

    function automatic bit m_win(input int h, input int v);
        return (h >= X0) && (h < X0 + IMG_W) && (v >= Y0) && (v < Y0 + IMG_H);
    endfunction

    function automatic bit m_ring(input int h, input int v);
        return ((h == X0 - 1 || h == X0 + IMG_W) && v >= Y0 - 1 && v <= Y0 + IMG_H) ||
               ((v == Y0 - 1 || v == Y0 + IMG_H) && h >= X0 - 1 && h <= X0 + IMG_W);
    endfunction

    function automatic logic [7:0] m_pix(input int h, input int v);
        if (BORDER && m_ring(h, v) && m_de(h, v)) return 8'hFF;
        if (m_win(h, v) && m_valid) return mem_model[(v - Y0) * IMG_W + (h - X0)];
        return 8'h00;
    endfunction

    function automatic int pix_errors();
        int n = 0;
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++)
                if (obs_pix[v][h] !== m_pix(h, v)) n++;
        return n;
    endfunction

    function automatic int sync_errors();
        int n = 0;
        for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++)
                if (obs_de[v][h] !== m_de(h, v) || obs_hs[v][h] !== m_hs(h) ||
                    obs_vs[v][h] !== m_vs(v)) n++;
        return n;
    endfunction

    // Records one full raster frame starting at the next frame boundary.
    task automatic capture_frame(output bit aligned);
        int p;
        aligned = 1'b0;
        for (int k = 0; k < FT + 4 && !aligned; k++) begin
            @(negedge CLK);
            if (cyc >= 2 && (cyc - 2) % FT == 0) aligned = 1'b1;
        end
        if (aligned) begin
            for (int k = 0; k < FT; k++) begin
                p = cyc - 2;
                obs_pix[(p / HT) % VT][p % HT] = VGA_PIXEL_O;
                obs_de[(p / HT) % VT][p % HT]  = VGA_DE_O;
                obs_hs[(p / HT) % VT][p % HT]  = VGA_HSYNC_O;
                obs_vs[(p / HT) % VT][p % HT]  = VGA_VSYNC_O;
                @(negedge CLK);
            end
        end
    endtask

    task automatic drive_pixel(input logic [7:0] d, input logic start, inout int done_cnt);
        @(negedge CLK);
        if (FRAME_WR_DONE_O === 1'b1) done_cnt++;
        FRAME_START_I = start;
        PIXEL_EN_I    = 1'b1;
        PIXEL_I       = d;
        if (start) m_wr = 0;
        mem_model[m_wr] = d;
        if (m_wr == NPIX - 1) begin
            m_wr    = 0;
            m_valid = 1'b1;
        end else begin
            m_wr++;
        end
    endtask

    task automatic drive_idle(inout int done_cnt);
        @(negedge CLK);
        if (FRAME_WR_DONE_O === 1'b1) done_cnt++;
        FRAME_START_I = 1'b0;
        PIXEL_EN_I    = 1'b0;
    endtask

    task automatic test_reset();
        int rise;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if ({VGA_PIXEL_O, VGA_HSYNC_O, VGA_VSYNC_O, VGA_DE_O, FRAME_WR_DONE_O} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 000",
                     {VGA_PIXEL_O, VGA_HSYNC_O, VGA_VSYNC_O, VGA_DE_O, FRAME_WR_DONE_O});
        end
        RST = 1'b0;
        for (int k = 0; k < 100 && cyc < 27; k++) @(negedge CLK);
        checks++;
        if (VGA_DE_O !== 1'b1) begin
            failures++;
            $display("FAIL de_before_midline_reset: got %b required 1", VGA_DE_O);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({VGA_PIXEL_O, VGA_HSYNC_O, VGA_VSYNC_O, VGA_DE_O, FRAME_WR_DONE_O} !== 12'h000) begin
            failures++;
            $display("FAIL midline_reset_outputs: got %h required 000",
                     {VGA_PIXEL_O, VGA_HSYNC_O, VGA_VSYNC_O, VGA_DE_O, FRAME_WR_DONE_O});
        end
        repeat (2) @(negedge CLK);
        RST     = 1'b0;
        m_wr    = 0;
        m_valid = 1'b0;
        rise    = -1;
        for (int k = 0; k < 3 * HT && rise < 0; k++) begin
            @(negedge CLK);
            if (VGA_HSYNC_O === 1'b1) rise = cyc;
        end
        checks++;
        if (rise !== HVIS + HFP + 2) begin
            failures++;
            $display("FAIL hsync_first_rise: got cycle %0d required %0d", rise, HVIS + HFP + 2);
        end
        rise = -1;
        for (int k = 0; k < FT + HT && rise < 0; k++) begin
            if (VGA_VSYNC_O === 1'b1) rise = cyc;
            else @(negedge CLK);
        end
        checks++;
        if (rise !== (VVIS + VFP) * HT + 2) begin
            failures++;
            $display("FAIL vsync_first_rise: got cycle %0d required %0d",
                     rise, (VVIS + VFP) * HT + 2);
        end
    endtask

    task automatic test_free_run();
        bit aligned;
        int bad_hs_lines, bad_de_lines, vs_total, pulses, n_hs, n_de;
        logic prev;
        capture_frame(aligned);
        checks++;
        if (aligned !== 1'b1) begin
            failures++;
            $display("FAIL free_run_align: got %b required 1", aligned);
        end
        bad_hs_lines = 0; bad_de_lines = 0; vs_total = 0; pulses = 0;
        prev = obs_hs[VT-1][HT-1];
        for (int v = 0; v < VT; v++) begin
            n_hs = 0; n_de = 0;
            for (int h = 0; h < HT; h++) begin
                n_hs += int'(obs_hs[v][h]);
                n_de += int'(obs_de[v][h]);
                vs_total += int'(obs_vs[v][h]);
                if (obs_hs[v][h] === 1'b1 && prev !== 1'b1) pulses++;
                prev = obs_hs[v][h];
            end
            if (n_hs != HSW) bad_hs_lines++;
            if (n_de != ((v < VVIS) ? HVIS : 0)) bad_de_lines++;
        end
        checks++;
        if (bad_hs_lines !== 0) begin
            failures++;
            $display("FAIL hsync_width: got %0d bad lines required 0", bad_hs_lines);
        end
        checks++;
        if (bad_de_lines !== 0) begin
            failures++;
            $display("FAIL de_width: got %0d bad lines required 0", bad_de_lines);
        end
        checks++;
        if (vs_total !== VSW * HT) begin
            failures++;
            $display("FAIL vsync_width: got %0d required %0d", vs_total, VSW * HT);
        end
        checks++;
        if (pulses !== VT) begin
            failures++;
            $display("FAIL line_count: got %0d required %0d", pulses, VT);
        end
        checks++;
        if (sync_errors() !== 0) begin
            failures++;
            $display("FAIL sync_raster: got %0d bad cycles required 0", sync_errors());
        end
    endtask

    task automatic test_no_pixels();
        bit aligned;
        int nonzero;
        capture_frame(aligned);
        nonzero = 0;
        for (int v = Y0; v < Y0 + IMG_H; v++)
            for (int h = X0; h < X0 + IMG_W; h++)
                if (obs_pix[v][h] !== 8'h00) nonzero++;
        checks++;
        if (aligned !== 1'b1 || nonzero !== 0) begin
            failures++;
            $display("FAIL no_pixels_window: got %0d nonzero required 0", nonzero);
        end
        checks++;
        if (pix_errors() !== 0) begin
            failures++;
            $display("FAIL no_pixels_frame: got %0d bad pixels required 0", pix_errors());
        end
    endtask

    task automatic test_ramp_frame();
        bit aligned;
        int done_cnt = 0;
        logic last_done;
        for (int i = 0; i < NPIX; i++) begin
            if ($urandom_range(0, 3) == 0) drive_idle(done_cnt);
            drive_pixel(8'(i), 1'b0, done_cnt);
        end
        @(negedge CLK);
        last_done = FRAME_WR_DONE_O;
        if (last_done === 1'b1) done_cnt++;
        PIXEL_EN_I = 1'b0;
        repeat (3) drive_idle(done_cnt);
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL ramp_done_count: got %0d required 1", done_cnt);
        end
        checks++;
        if (last_done !== 1'b1) begin
            failures++;
            $display("FAIL ramp_done_timing: got %b required 1", last_done);
        end
        capture_frame(aligned);
        checks++;
        if (obs_pix[Y0][X0] !== 8'h00) begin
            failures++;
            $display("FAIL ramp_first: got %h required 00", obs_pix[Y0][X0]);
        end
        checks++;
        if (obs_pix[Y0][X0+1] !== 8'h01) begin
            failures++;
            $display("FAIL ramp_second: got %h required 01", obs_pix[Y0][X0+1]);
        end
        checks++;
        if (obs_pix[Y0+1][X0] !== 8'h10) begin
            failures++;
            $display("FAIL ramp_row1: got %h required 10", obs_pix[Y0+1][X0]);
        end
        checks++;
        if (aligned !== 1'b1 || pix_errors() !== 0) begin
            failures++;
            $display("FAIL ramp_frame: got %0d bad pixels required 0", pix_errors());
        end
    endtask

    task automatic test_start_collision();
        bit aligned;
        int done_cnt = 0;
        for (int i = 0; i < 50; i++) drive_pixel(8'($urandom), 1'b0, done_cnt);
        drive_pixel(8'hAB, 1'b1, done_cnt);
        drive_pixel(8'h5C, 1'b0, done_cnt);
        repeat (3) drive_idle(done_cnt);
        checks++;
        if (done_cnt !== 0) begin
            failures++;
            $display("FAIL collision_no_done: got %0d required 0", done_cnt);
        end
        capture_frame(aligned);
        checks++;
        if (obs_pix[Y0][X0] !== 8'hAB) begin
            failures++;
            $display("FAIL collision_addr0: got %h required ab", obs_pix[Y0][X0]);
        end
        checks++;
        if (obs_pix[Y0][X0+1] !== 8'h5C) begin
            failures++;
            $display("FAIL collision_addr1: got %h required 5c", obs_pix[Y0][X0+1]);
        end
        checks++;
        if (aligned !== 1'b1 || pix_errors() !== 0) begin
            failures++;
            $display("FAIL collision_frame: got %0d bad pixels required 0", pix_errors());
        end
    endtask

    task automatic test_border();
        bit aligned;
        logic [7:0] ring_exp;
        ring_exp = BORDER ? 8'hFF : 8'h00;
        capture_frame(aligned);
        checks++;
        if (obs_pix[Y0][X0-1] !== ring_exp) begin
            failures++;
            $display("FAIL border_left: got %h required %h", obs_pix[Y0][X0-1], ring_exp);
        end
        checks++;
        if (obs_pix[Y0][X0-2] !== 8'h00) begin
            failures++;
            $display("FAIL border_outside: got %h required 00", obs_pix[Y0][X0-2]);
        end
        checks++;
        if (obs_pix[Y0+IMG_H][X0+IMG_W] !== ring_exp) begin
            failures++;
            $display("FAIL border_corner: got %h required %h",
                     obs_pix[Y0+IMG_H][X0+IMG_W], ring_exp);
        end
        checks++;
        if (aligned !== 1'b1 || pix_errors() !== 0) begin
            failures++;
            $display("FAIL border_frame: got %0d bad pixels required 0", pix_errors());
        end
    endtask

    task automatic test_back_to_back();
        bit aligned;
        int done_cnt = 0;
        for (int i = 0; i < NPIX + 5; i++) drive_pixel(8'($urandom), (i == 0), done_cnt);
        repeat (3) drive_idle(done_cnt);
        checks++;
        if (done_cnt !== 1) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d required 1", done_cnt);
        end
        capture_frame(aligned);
        checks++;
        if (aligned !== 1'b1 || pix_errors() !== 0) begin
            failures++;
            $display("FAIL b2b_frame: got %0d bad pixels required 0", pix_errors());
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_no_pixels();
        test_ramp_frame();
        test_start_collision();
        test_border();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
